// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Shares one single-port data memory between the core load/store path and a
// host (loader/bench) port. The core has fixed priority. After STARVE_LIMIT
// consecutive contested core wins the host is forced through on the next
// contested cycle. Read data returns one cycle after the grant, qualified by a
// registered per-port valid.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   core_req/we/addr/wdata core request, held until core_gnt
//   core_gnt              core access performed this cycle (combinational)
//   core_rvalid/rdata     core read return (rdata is 0 while rvalid is low)
//   host_*                same set of signals for the host port
//   mem_addr/we/wdata     memory command from the granted port
//   mem_rdata             memory read data, one cycle after mem_addr
//   conflict_cnt          saturating count of cycles with both requests high
module data_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [15:0]           conflict_cnt
);

  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] ONE   = SW'(1);

  logic [SW-1:0] r_starve_cnt;
  logic          r_core_rvalid;
  logic          r_host_rvalid;
  logic [15:0]   r_conflict_cnt;

  logic          w_both;
  logic          w_core_gnt;
  logic          w_host_gnt;

  assign w_both = core_req & host_req;

  // Grant decision. Reset suppresses every grant so no memory write and no
  // read return can originate from a reset cycle.
  always_comb begin
    w_core_gnt = 1'b0;
    w_host_gnt = 1'b0;
    if (!reset) begin
      if (w_both) begin
        if (r_starve_cnt >= LIMIT) begin
          w_host_gnt = 1'b1;
        end else begin
          w_core_gnt = 1'b1;
        end
      end else if (core_req) begin
        w_core_gnt = 1'b1;
      end else if (host_req) begin
        w_host_gnt = 1'b1;
      end
    end
  end

  assign core_gnt = w_core_gnt;
  assign host_gnt = w_host_gnt;

  // Memory command mux; with no grant the core fields are presented idle.
  always_comb begin
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    mem_we    = 1'b0;
    if (w_host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we;
    end else if (w_core_gnt) begin
      mem_we    = core_we;
    end
  end

  // Contested core-win run length. Any host grant or host idle cycle ends
  // the run, so a host that drops its request starts a fresh run.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_host_gnt || !host_req) begin
      r_starve_cnt <= '0;
    end else if (w_both && w_core_gnt && (r_starve_cnt < LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + ONE;
    end
  end

  // Read-return tags: one cycle after a granted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_core_rvalid <= 1'b0;
      r_host_rvalid <= 1'b0;
    end else begin
      r_core_rvalid <= w_core_gnt & ~core_we;
      r_host_rvalid <= w_host_gnt & ~host_we;
    end
  end

  // A read granted just before reset rises has already set its tag; masking
  // with reset drops that return instead of letting it escape during reset.
  assign core_rvalid = r_core_rvalid & ~reset;
  assign host_rvalid = r_host_rvalid & ~reset;
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict_cnt <= '0;
    end else if (w_both && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed stimulus with hand-computed grants and
// read data; expected read returns are queued at grant time and a monitor
// pops them whenever an rvalid appears.
module tb_data_mem_arbiter;

  logic       clk;
  logic       reset;
  logic       core_req, core_we;
  logic [7:0] core_addr, core_wdata;
  logic       core_gnt, core_rvalid;
  logic [7:0] core_rdata;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
  logic [15:0] conflict_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit         is_host;
    logic [7:0] data;
  } rd_exp_t;

  rd_exp_t sb_q[$];

  data_mem_arbiter #(
    .ADDR_WIDTH  (8),
    .DATA_WIDTH  (8),
    .STARVE_LIMIT(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_gnt    (core_gnt),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory: read-before-write, one-cycle read latency.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every falling edge, compare any read return against the queue.
  always @(negedge clk) begin
    if (core_gnt && host_gnt) chk("both_gnt", 1, 0);
    if (core_rvalid && host_rvalid) chk("both_rvalid", 1, 0);
    if (core_rvalid || host_rvalid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rvalid", {30'd0, host_rvalid, core_rvalid}, 0);
      end else begin
        rd_exp_t e;
        e = sb_q.pop_front();
        chk("rvalid_port", int'(host_rvalid), int'(e.is_host));
        chk("rdata", int'(e.is_host ? host_rdata : core_rdata), int'(e.data));
      end
    end else begin
      if (core_rdata != 8'h00) chk("core_rdata_idle", int'(core_rdata), 0);
      if (host_rdata != 8'h00) chk("host_rdata_idle", int'(host_rdata), 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One bus cycle: drive after the rising edge, check grants/mux mid-cycle,
  // and queue the expected read return if a read is granted.
  task automatic cycle_op(input bit cr, input bit cw, input logic [7:0] ca,
                          input logic [7:0] cd, input bit hr, input bit hw,
                          input logic [7:0] ha, input logic [7:0] hd,
                          input bit eg_c, input bit eg_h,
                          input logic [7:0] exp_rd, input string nm);
    rd_exp_t e;
    @(posedge clk); #1;
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    @(negedge clk);
    chk({nm, "_core_gnt"}, int'(core_gnt), int'(eg_c));
    chk({nm, "_host_gnt"}, int'(host_gnt), int'(eg_h));
    if (eg_h) begin
      chk({nm, "_mem_addr"}, int'(mem_addr), int'(ha));
      chk({nm, "_mem_we"}, int'(mem_we), int'(hw));
      if (hw) chk({nm, "_mem_wdata"}, int'(mem_wdata), int'(hd));
    end else if (eg_c) begin
      chk({nm, "_mem_addr"}, int'(mem_addr), int'(ca));
      chk({nm, "_mem_we"}, int'(mem_we), int'(cw));
      if (cw) chk({nm, "_mem_wdata"}, int'(mem_wdata), int'(cd));
    end else begin
      chk({nm, "_idle_mem_we"}, int'(mem_we), 0);
      chk({nm, "_idle_mem_addr"}, int'(mem_addr), int'(ca));
    end
    if (eg_c && !cw) begin e.is_host = 1'b0; e.data = exp_rd; sb_q.push_back(e); end
    if (eg_h && !hw) begin e.is_host = 1'b1; e.data = exp_rd; sb_q.push_back(e); end
  endtask

  task automatic idle(input string nm);
    cycle_op(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, nm);
  endtask

  task automatic rst_pulse();
    @(posedge clk); #1;
    reset = 1'b1; core_req = 1'b0; host_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    // Reset held two cycles with both requesters active (writes).
    reset = 1'b1;
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'h33; core_wdata = 8'hEE;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h44; host_wdata = 8'hDD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_core_gnt", int'(core_gnt), 0);
    chk("rst_host_gnt", int'(host_gnt), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_core_rvalid", int'(core_rvalid), 0);
    chk("rst_host_rvalid", int'(host_rvalid), 0);
    chk("rst_core_rdata", int'(core_rdata), 0);
    chk("rst_host_rdata", int'(host_rdata), 0);
    #1;
    reset = 1'b0; core_req = 1'b0; host_req = 1'b0;
    @(negedge clk);
    chk("rst_conflict_cnt", int'(conflict_cnt), 0);

    // Preload and host-only write/readback.
    cycle_op(1, 1, 8'h01, 8'h11, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, "core_wr01");
    cycle_op(0, 0, 8'h00, 8'h00, 1, 1, 8'h02, 8'h22, 0, 1, 8'h00, "host_wr02");
    cycle_op(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'hA5, 0, 1, 8'h00, "host_wr10");
    cycle_op(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0, 1, 8'hA5, "host_rd10");
    idle("idle_a");

    // Interleaved reads: core returns in N+1, host in N+2.
    cycle_op(1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h11, "core_rd01");
    cycle_op(0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1, 8'h22, "host_rd02");
    chk("ilv_core_rvalid_n1", int'(core_rvalid), 1);
    chk("ilv_host_rvalid_n1", int'(host_rvalid), 0);
    idle("idle_b");
    chk("ilv_host_rvalid_n2", int'(host_rvalid), 1);
    chk("ilv_core_rvalid_n2", int'(core_rvalid), 0);
    idle("idle_c");

    // Read then write same address back-to-back: read sees the old value.
    cycle_op(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'hA5, "rtw_core_rd");
    cycle_op(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'h5A, 0, 1, 8'h00, "rtw_host_wr");
    cycle_op(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0, 1, 8'h5A, "rtw_host_rd");
    idle("idle_d");

    // Continuous contention: C,C,C,C,H,C,C,C,C,H and conflict_cnt = 10.
    rst_pulse();
    for (int i = 0; i < 10; i++) begin
      bit eh;
      eh = (i == 4) || (i == 9);
      cycle_op(1, 1, 8'h80, 8'h01, 1, 1, 8'h90, 8'h02, !eh, eh, 8'h00, "contend");
    end
    idle("idle_e");
    chk("contend_conflict_cnt", int'(conflict_cnt), 10);

    // Host drops its request after 3 contested core wins; run restarts.
    for (int i = 0; i < 3; i++)
      cycle_op(1, 1, 8'h81, 8'h03, 1, 1, 8'h91, 8'h04, 1, 0, 8'h00, "drop_pre");
    cycle_op(1, 1, 8'h81, 8'h03, 0, 1, 8'h91, 8'h04, 1, 0, 8'h00, "drop_gap");
    for (int i = 0; i < 5; i++)
      cycle_op(1, 1, 8'h81, 8'h03, 1, 1, 8'h91, 8'h04, i != 4, i == 4, 8'h00, "drop_post");
    idle("idle_f");

    // Reset asserted the cycle after a granted core read: no return.
    cycle_op(1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, "midrst_rd");
    void'(sb_q.pop_back());
    @(posedge clk); #1;
    reset = 1'b1; core_req = 1'b0;
    @(negedge clk);
    chk("midrst_core_rvalid", int'(core_rvalid), 0);
    chk("midrst_core_rdata", int'(core_rdata), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Conflict counter saturation.
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'hF0; core_wdata = 8'h00;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'hF1; host_wdata = 8'h00;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("sat_near", int'(conflict_cnt), 16'hFFFE);
    repeat (70000 - 65534) @(posedge clk);
    @(negedge clk);
    chk("sat_hold", int'(conflict_cnt), 16'hFFFF);
    #1;
    core_req = 1'b0; host_req = 1'b0;

    // Every queued read return must have been observed.
    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter that shares the single-port 256x8 data memory between the tinyarch core (load/store path) and a host port used by the bench or loader for preload and readback. The core has fixed priority; a starvation counter guarantees the host a slot after a bounded run of core wins. The arbiter drives the memory port, returns read data with a registered valid to the winning requester, and keeps a saturating conflict counter for performance checks.

## Interface
- ADDR_WIDTH, 8, memory address width
- DATA_WIDTH, 8, memory data width
- STARVE_LIMIT, 4, consecutive contested core wins before the host is forced through (0 = host wins every contest)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- core_req  in  1  core access request, held until core_gnt
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_WIDTH  core address
- core_wdata  in  DATA_WIDTH  core write data
- core_gnt  out  1  core access performed this cycle (combinational)
- core_rvalid  out  1  core read data valid (registered)
- core_rdata  out  DATA_WIDTH  core read data
- host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata: same widths and meaning for the host port
- mem_addr  out  ADDR_WIDTH  memory address
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after the address is presented
- conflict_cnt  out  16  saturating count of cycles with both requests high

## Operation
- Request rule: a requester holds req, we, addr and wdata stable until it sees gnt high; one access is performed per gnt cycle. A requester may keep req high after gnt to issue back-to-back accesses.
- Grant (combinational, same cycle as req):
  - neither requests: no gnt; mem_we=0; mem_addr/mem_wdata hold the core fields.
  - one requests: that one is granted.
  - both request: host is granted if starve_cnt >= STARVE_LIMIT, otherwise core.
- Memory mux: mem_addr, mem_we and mem_wdata come from the granted port. mem_we = granted we.
- starve_cnt (internal, width clog2(STARVE_LIMIT+1), minimum 1 bit):
  - +1 when both request and core is granted.
  - cleared when host is granted or host_req is low.
  - never exceeds STARVE_LIMIT.
- Read return:
  - a granted read (we=0) sets that port's rvalid on the next cycle.
  - rdata = mem_rdata while rvalid is high, else 0.
  - writes never produce rvalid.
  - core_rvalid and host_rvalid are never high together.
- conflict_cnt: +1 on every cycle with core_req & host_req; holds at 16'hFFFF.
- Reset (while high): gnt outputs forced 0, mem_we=0, starve_cnt=0, both rvalid=0, conflict_cnt=0. A read granted in the cycle before reset asserts produces no rvalid.

## Timing
- Reset values: core_gnt=0, host_gnt=0, core_rvalid=0, host_rvalid=0, core_rdata=0, host_rdata=0, mem_we=0, conflict_cnt=0.
- Grant latency: 0 cycles. Write completes at the clock edge ending the gnt cycle. Read latency: 1 cycle (gnt in cycle N, rvalid/rdata in N+1).
- Throughput: one access per cycle, with no bubble between back-to-back grants to the same or different ports.
- Worst-case host wait while the core streams: STARVE_LIMIT contested cycles, then the host is granted on the next contested cycle.
- Simultaneous read-then-write to the same address on consecutive cycles: the read returns the pre-write value. Read-during-write ordering is the memory's, and the arbiter adds no forwarding.

## Test plan
- Reset: hold reset 2 cycles with both reqs high -> no gnt, mem_we=0, rvalids 0, conflict_cnt=0 after release.
- Host only: host write addr 8'h10 data 8'hA5, then host read 8'h10 -> host_gnt each cycle; host_rvalid one cycle after the read gnt with host_rdata=8'hA5; core_rvalid stays 0.
- Contention, STARVE_LIMIT=4: core and host request continuously for 10 cycles -> grant sequence C,C,C,C,H,C,C,C,C,H; conflict_cnt=10.
- Host drops req mid-run: core wins 3 contested cycles, host_req low 1 cycle, contest resumes -> starve_cnt restarts, so the host is granted on the 5th contested cycle after resumption.
- Interleaved reads: core reads 8'h01 (value 8'h11) in cycle N, host reads 8'h02 (value 8'h22) in cycle N+1 -> core_rvalid/8'h11 in N+1, host_rvalid/8'h22 in N+2, never overlapping.
- Reset mid-read: core read granted in cycle N, reset high in N+1 -> core_rvalid stays 0. Also force conflicts for 70000 cycles -> conflict_cnt saturates at 16'hFFFF.
